// File: rtl/vram_port.sv
// Single-port VRAM front end: alternates one synchronous RAM between VDP
// scan-out reads (phase 0) and buffered CPU writes drained from a FIFO (phase 1).
module vram_port #(
  parameter logic [2:0] WINDOW  = 3'h3,
  parameter int         FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] vdp_addr,
  output logic [7:0]  vdp_data,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_we,
  output logic        cpu_ready,
  output logic        overflow,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_rdata
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   FULL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  logic               phase_q, phase_d;
  logic               rd_hit_q, rd_hit_d;
  logic [7:0]         vdp_data_q, vdp_data_d;
  logic               overflow_q, overflow_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [12:0]        fifo_addr_q [DEPTH];
  logic [7:0]         fifo_data_q [DEPTH];
  logic               push, pop;

  // cpu_ready looks only at the current count, so a same-cycle pop never
  // frees a slot for a push into a full FIFO.
  assign cpu_ready = (count_q != FULL);
  assign vdp_data  = vdp_data_q;
  assign overflow  = overflow_q;

  // Next-state: slot phase, read capture, FIFO bookkeeping, sticky overflow.
  always_comb begin
    push       = cpu_we && cpu_ready && (cpu_addr[15:13] == WINDOW);
    pop        = phase_q && (count_q != '0);
    phase_d    = ~phase_q;
    rd_hit_d   = rd_hit_q;
    vdp_data_d = vdp_data_q;
    if (!phase_q) begin
      rd_hit_d = (vdp_addr[15:13] == WINDOW);
    end else begin
      vdp_data_d = rd_hit_q ? ram_rdata : 8'h00;
    end
    overflow_d = overflow_q | (cpu_we & ~cpu_ready);
    wr_ptr_d   = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // RAM port: VDP address in the read slot, FIFO head in the write slot.
  always_comb begin
    ram_wdata = fifo_data_q[rd_ptr_q];
    if (phase_q) begin
      ram_addr = fifo_addr_q[rd_ptr_q];
      ram_we   = pop;
    end else begin
      ram_addr = vdp_addr[12:0];
      ram_we   = 1'b0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= 1'b0;
      rd_hit_q   <= 1'b0;
      vdp_data_q <= 8'h00;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      phase_q    <= phase_d;
      rd_hit_q   <= rd_hit_d;
      vdp_data_q <= vdp_data_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= cpu_addr[12:0];
      fifo_data_q[wr_ptr_q] <= cpu_data;
    end
  end

endmodule

// File: tb/tb_vram_port.sv
// Self-checking bench for vram_port: behavioural RAM, cycle model of the
// slot/FIFO rules, and a scoreboard of accepted writes matched at the RAM port.
module tb_vram_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] vdp_addr;
  logic [7:0]  vdp_data;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;
  logic        cpu_ready;
  logic        overflow;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [20:0] exp_q [$];
  logic [20:0] exp_e;
  bit          m_phase = 1'b0;
  int          m_count = 0;
  int          writes_seen = 0;
  int          w0;
  logic [7:0]  mem [0:8191];

  vram_port dut (
    .clk(clk), .reset(reset), .vdp_addr(vdp_addr), .vdp_data(vdp_data),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .cpu_ready(cpu_ready), .overflow(overflow), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-before-write.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Mid-cycle monitor: slot usage and in-order arrival of accepted writes.
  always @(negedge clk) begin
    if (!reset) begin
      if (!m_phase) begin
        check("rd_slot", {19'd0, ram_we, ram_addr}, {19'd0, 1'b0, vdp_addr[12:0]});
      end else begin
        check("wr_slot_we", {31'd0, ram_we}, {31'd0, m_count != 0});
      end
      if (ram_we) begin
        writes_seen++;
        check("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_e = exp_q.pop_front();
          check("wr_addr", {19'd0, ram_addr}, {19'd0, exp_e[20:8]});
          check("wr_data", {24'd0, ram_wdata}, {24'd0, exp_e[7:0]});
        end
      end
    end
  end

  // One clock of stimulus; entered and left #1 after a rising edge.
  task automatic cycle(input logic we, input logic [15:0] addr, input logic [7:0] data);
    logic acc;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_data = data;
    check("cpu_ready", {31'd0, cpu_ready}, {31'd0, m_count != 4});
    acc = we && (m_count != 4) && (addr[15:13] == 3'h3);
    if (acc) exp_q.push_back({addr[12:0], data});
    @(posedge clk);
    m_count = m_count + (acc ? 1 : 0) - ((m_phase && m_count != 0) ? 1 : 0);
    m_phase = ~m_phase;
    #1;
    cpu_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic align_phase0();
    if (m_phase) idle(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    m_count = 0;
    m_phase = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
    vdp_addr = 16'h0000;
    mem[13'h0123] <= 8'hA5;
    mem[13'h0040] <= 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_vdp", {24'd0, vdp_data}, 32'h00);
    check("rst_we", {31'd0, ram_we}, 32'd0);

    // Read path: in-window hit, then out-of-window alias reads zero.
    vdp_addr = 16'h6123;
    idle(3);
    check("rd_hit", {24'd0, vdp_data}, 32'hA5);
    vdp_addr = 16'h8123;
    idle(3);
    check("rd_miss", {24'd0, vdp_data}, 32'h00);

    // Write then read back through the scan-out path.
    vdp_addr = 16'h6040;
    w0 = writes_seen;
    cycle(1'b1, 16'h6040, 8'h5A);
    idle(4);
    check("wr_rd_data", {24'd0, vdp_data}, 32'h5A);
    check("wr_once", writes_seen - w0, 32'd1);

    // Out-of-window write is dropped without overflow.
    w0 = writes_seen;
    cycle(1'b1, 16'h2000, 8'h77);
    idle(4);
    check("win_no_we", writes_seen - w0, 32'd0);
    check("win_no_ovf", {31'd0, overflow}, 32'd0);

    // Build count to 2, then push only in write slots so push and pop coincide.
    align_phase0();
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h6100 + 16'(i), 8'h10 + 8'(i));
    for (int i = 3; i < 13; ) begin
      if (m_phase) begin
        cycle(1'b1, 16'h6100 + 16'(i), 8'h10 + 8'(i));
        i++;
      end else begin
        idle(1);
      end
    end
    idle(8);
    check("wrap_drained", exp_q.size(), 32'd0);
    check("wrap_no_ovf", {31'd0, overflow}, 32'd0);

    // Back-to-back strobes overrun the FIFO.
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h6000 + 16'(i), 8'hC0 + 8'(i));
    check("full_ovf", {31'd0, overflow}, 32'd1);
    idle(12);
    check("full_drained", exp_q.size(), 32'd0);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset with three entries pending.
    align_phase0();
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h6200 + 16'(i), 8'h30 + 8'(i));
    do_reset();
    check("mid_rst_ready", {31'd0, cpu_ready}, 32'd1);
    check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check("mid_rst_vdp", {24'd0, vdp_data}, 32'h00);
    w0 = writes_seen;
    idle(8);
    check("mid_rst_no_we", writes_seen - w0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
